inert_seq: RTL and testbench

Parametrised SPI read sequencer for the inertial sensor path, the generalised successor to the fixed five-channel inertial interface. After reset it waits a power-up interval and issues a configurable table of register writes. It then services each data-ready interrupt by reading a configurable number of 16-bit channels as low/high byte pairs, publishing all channels atomically. It sits between the SPI master and the inertial integrator, and adds an interrupt watchdog with automatic re-initialisation, overrun counting and a software re-init request.

---
 rtl/inert_seq_if.sv | 10 +
 rtl/inert_seq.sv | 181 ++++++++++++++++++
 tb/tb_inert_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/inert_seq_if.sv
// SPI master handshake between the inertial sequencer and the SPI master.
interface inert_seq_if;
   logic        spi_wrt;      // one-cycle transaction start
   logic [15:0] spi_cmd;      // command word, held until spi_done
   logic        spi_done;     // transaction-complete pulse
   logic [15:0] spi_rd_data;  // read data, register byte in [15:8]

   modport master (output spi_wrt, spi_cmd, input spi_done, spi_rd_data);
   modport slave  (input spi_wrt, spi_cmd, output spi_done, spi_rd_data);
endinterface

// File: rtl/inert_seq.sv
// Inertial sensor SPI sequencer: power-up delay, init write table, then
// per-interrupt burst read of NUM_CH 16-bit channels published atomically.
// Adds interrupt watchdog, overrun counter and software re-init.
module inert_seq #(
   parameter int                     NUM_CH    = 5,
   parameter int                     NUM_INIT  = 4,
   parameter logic [NUM_INIT*16-1:0] INIT_CMDS = {16'h1460, 16'h1162, 16'h1062, 16'h0D02},
   parameter logic [6:0]             RD_BASE   = 7'h22,
   parameter int                     PWR_CYC   = 65535,
   parameter int                     TMO_CYC   = 1000000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   INT,
   input  logic                   reinit,
   inert_seq_if.master            spi,
   output logic                   init_done,
   output logic [NUM_CH*16-1:0]   data,
   output logic                   vld,
   output logic                   tmo_err,
   output logic [7:0]             ovr_cnt
);
   localparam int NB = 2 * NUM_CH;
   localparam int JW = $clog2(NB);
   localparam int IW = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1;
   localparam int DW = $clog2(PWR_CYC + 1);
   localparam int WW = $clog2(TMO_CYC + 1);

   localparam logic [DW-1:0] DLY_LAST = DW'(PWR_CYC - 1);
   localparam logic [WW-1:0] WD_LAST  = WW'(TMO_CYC - 1);
   localparam logic [JW-1:0] J_LAST   = JW'(NB - 1);
   localparam logic [IW-1:0] I_LAST   = IW'(NUM_INIT - 1);

   typedef enum logic [2:0] {
      PWRUP, INIT_WR, INIT_WAIT, INIT_GAP, IDLE, RD_WR, RD_WAIT, PUBLISH
   } state_t;

   state_t              state, state_nxt;
   logic [DW-1:0]       dly, dly_nxt;
   logic [WW-1:0]       wd, wd_nxt;
   logic [IW-1:0]       i_idx, i_nxt;
   logic [JW-1:0]       j_idx, j_nxt;
   logic [15:0]         cmd_nxt;
   logic                done_set, done_clr, tmo_set, sh_wr, pub;
   logic                int_m, int_s, int_q;
   logic [NB-1:0][7:0]  shadow;

   // Only the register byte of the read word matters.
   logic unused_rd_lo;
   assign unused_rd_lo = ^spi.spi_rd_data[7:0];

   // INT is asynchronous: two-flop synchroniser plus a delayed copy for edge detect.
   always_ff @(posedge clk) begin
      if (rst) {int_m, int_s, int_q} <= '0;
      else     {int_m, int_s, int_q} <= {INT, int_m, int_s};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= PWRUP;
      else     state <= state_nxt;
   end

   // Next-state, counter updates and control strobes.
   always_comb begin
      state_nxt = state;
      dly_nxt   = '0;
      wd_nxt    = '0;
      i_nxt     = i_idx;
      j_nxt     = j_idx;
      done_set  = 1'b0;
      done_clr  = 1'b0;
      tmo_set   = 1'b0;
      sh_wr     = 1'b0;
      pub       = 1'b0;
      case (state)
         PWRUP: begin
            if (dly == DLY_LAST) begin
               state_nxt = INIT_WR;
               i_nxt     = '0;
            end else dly_nxt = dly + DW'(1);
         end
         INIT_WR: state_nxt = INIT_WAIT;
         INIT_WAIT: begin
            if (spi.spi_done) begin
               if (i_idx == I_LAST) begin
                  done_set  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  i_nxt     = i_idx + IW'(1);
                  state_nxt = INIT_GAP;
               end
            end
         end
         INIT_GAP: begin
            if (dly == DLY_LAST) state_nxt = INIT_WR;
            else                 dly_nxt   = dly + DW'(1);
         end
         IDLE: begin
            if (int_s) begin
               state_nxt = RD_WR;
               j_nxt     = '0;
            end else if (wd == WD_LAST) begin
               tmo_set   = 1'b1;
               done_clr  = 1'b1;
               state_nxt = PWRUP;
            end else wd_nxt = wd + WW'(1);
         end
         RD_WR: state_nxt = RD_WAIT;
         RD_WAIT: begin
            if (spi.spi_done) begin
               sh_wr = 1'b1;
               if (j_idx == J_LAST) state_nxt = PUBLISH;
               else begin
                  j_nxt     = j_idx + JW'(1);
                  state_nxt = RD_WR;
               end
            end
         end
         PUBLISH: begin
            pub       = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = PWRUP;
      endcase

      // Re-init beats spi_done/int_s; a partial burst is simply abandoned.
      if (reinit && state != PWRUP) begin
         state_nxt = PWRUP;
         done_clr  = 1'b1;
         done_set  = 1'b0;
         tmo_set   = 1'b0;
         sh_wr     = 1'b0;
         pub       = 1'b0;
         dly_nxt   = '0;
         wd_nxt    = '0;
      end

      // Command is loaded on entry to a write state and held through the wait.
      cmd_nxt = spi.spi_cmd;
      if (state_nxt == INIT_WR)    cmd_nxt = INIT_CMDS[16*int'(i_nxt) +: 16];
      else if (state_nxt == RD_WR) cmd_nxt = {1'b1, RD_BASE + 7'(j_nxt), 8'h00};
   end

   // Counters, shadow capture, publish and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         dly         <= '0;
         wd          <= '0;
         i_idx       <= '0;
         j_idx       <= '0;
         shadow      <= '0;
         data        <= '0;
         vld         <= 1'b0;
         init_done   <= 1'b0;
         tmo_err     <= 1'b0;
         spi.spi_wrt <= 1'b0;
         spi.spi_cmd <= '0;
      end else begin
         dly         <= dly_nxt;
         wd          <= wd_nxt;
         i_idx       <= i_nxt;
         j_idx       <= j_nxt;
         vld         <= pub;
         spi.spi_wrt <= (state_nxt == INIT_WR) || (state_nxt == RD_WR);
         spi.spi_cmd <= cmd_nxt;
         if (sh_wr)    shadow[j_idx] <= spi.spi_rd_data[15:8];
         if (pub)      data <= shadow;
         if (done_set) init_done <= 1'b1;
         else if (done_clr) init_done <= 1'b0;
         if (tmo_set)  tmo_err <= 1'b1;
      end
   end

   // Missed interrupts: int_s rising while a burst is still in flight.
   always_ff @(posedge clk) begin
      if (rst) ovr_cnt <= '0;
      else if (int_s && !int_q && (state inside {RD_WR, RD_WAIT, PUBLISH}) && ovr_cnt != 8'hFF)
         ovr_cnt <= ovr_cnt + 8'd1;
   end
endmodule

// File: tb/tb_inert_seq.sv
// Directed bench for inert_seq: init table, burst read, overrun saturation,
// watchdog re-init, software reinit mid-burst and rst mid-init.
module tb_inert_seq;
   localparam int NC  = 5;
   localparam int PWR = 8;
   localparam int TMO = 100;
   localparam logic [79:0] PAT = 80'h0A09_0807_0605_0403_0201;

   logic        clk = 1'b0, rst = 1'b1, INT = 1'b0, reinit = 1'b0;
   logic        init_done, vld, tmo_err;
   logic [79:0] data;
   logic [7:0]  ovr_cnt;
   logic [15:0] init_tab [4] = '{16'h0D02, 16'h1062, 16'h1162, 16'h1460};

   int errors = 0, checks = 0, cyc = 0, vld_cnt = 0;
   int wrt_cyc = 0, done_cyc = 0, vld_edge = 0;

   inert_seq_if spi ();

   inert_seq #(.PWR_CYC(PWR), .TMO_CYC(TMO)) dut (
      .clk(clk), .rst(rst), .INT(INT), .reinit(reinit), .spi(spi),
      .init_done(init_done), .data(data), .vld(vld),
      .tmo_err(tmo_err), .ovr_cnt(ovr_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (vld === 1'b1) vld_cnt <= vld_cnt + 1;

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_wrt(input string tag);
      int n = 0;
      while (spi.spi_wrt !== 1'b1 && n < 400) begin tick(); n++; end
      chk({tag, "_wrt_seen"}, spi.spi_wrt, 1'b1);
      wrt_cyc = cyc;
   endtask

   // One SPI transaction as seen by the slave; optional INT toggles mid-wait.
   task automatic txn(input string tag, input logic [15:0] exp_cmd, input int dly,
                      input int tog, input logic [7:0] rb);
      wait_wrt(tag);
      chk({tag, "_cmd"}, spi.spi_cmd, exp_cmd);
      tick();
      chk({tag, "_wrt_1cyc"}, spi.spi_wrt, 1'b0);
      repeat (tog) begin
         INT = 1'b1; repeat (3) tick();
         INT = 1'b0; repeat (3) tick();
      end
      repeat (dly) tick();
      chk({tag, "_cmd_hold"}, spi.spi_cmd, exp_cmd);
      spi.spi_done = 1'b1; spi.spi_rd_data = {rb, 8'hA5};
      tick();
      spi.spi_done = 1'b0; spi.spi_rd_data = '0;
      done_cyc = cyc;
   endtask

   task automatic run_init(input int ref_cyc);
      int r = ref_cyc;
      for (int k = 0; k < 4; k++) begin
         txn($sformatf("init%0d", k), init_tab[k], 20, 0, 8'h00);
         chk($sformatf("init%0d_gap", k), 80'(wrt_cyc - r), 80'(PWR));
         chk($sformatf("init%0d_done", k), init_done, (k == 3));
         r = done_cyc;
      end
   endtask

   task automatic burst(input int tog);
      int k;
      INT = 1'b1;
      k = cyc + 1;
      for (int j = 0; j < 2*NC; j++) begin
         txn($sformatf("rd%0d", j), {1'b1, 7'(7'h22 + j), 8'h00}, 2, (j == 1) ? tog : 0, 8'(j + 1));
         if (j == 0) begin
            chk("rd_lat", 80'(wrt_cyc - k), 80'd2);
            INT = 1'b0;
         end
         if (j < 2*NC-1) chk("rd_b2b", spi.spi_wrt, 1'b1);
      end
      chk("pre_vld", vld, 1'b0);
      tick();
      chk("vld", vld, 1'b1);
      chk("data", data, PAT);
      vld_edge = cyc;
      tick();
      chk("vld_1cyc", vld, 1'b0);
   endtask

   initial begin
      int n, tmo_edge, re_edge, rst_edge, vsnap;
      spi.spi_done = 1'b0; spi.spi_rd_data = '0;

      // Reset and init sequence
      tick(); tick();
      chk("rst_wrt", spi.spi_wrt, 1'b0);
      chk("rst_cmd", spi.spi_cmd, 16'h0000);
      chk("rst_done", init_done, 1'b0);
      chk("rst_data", data, '0);
      chk("rst_vld", vld, 1'b0);
      chk("rst_tmo", tmo_err, 1'b0);
      chk("rst_ovr", ovr_cnt, 8'd0);
      rst_edge = cyc;
      rst = 1'b0;
      run_init(rst_edge);

      // Bursts with increasing overrun stimulus
      burst(0);   chk("ovr0", ovr_cnt, 8'd0);
      burst(1);   chk("ovr1", ovr_cnt, 8'd1);
      burst(10);  chk("ovr11", ovr_cnt, 8'd11);
      burst(300); chk("ovr_sat", ovr_cnt, 8'd255);

      // Watchdog: no INT after the last publish
      n = 0;
      while (tmo_err !== 1'b1 && n < 300) begin tick(); n++; end
      tmo_edge = cyc;
      chk("tmo_err", tmo_err, 1'b1);
      chk("tmo_lat", 80'(tmo_edge - vld_edge), 80'(TMO));
      chk("tmo_done_clr", init_done, 1'b0);
      run_init(tmo_edge);
      chk("tmo_sticky", tmo_err, 1'b1);

      // Software reinit after three bytes of a burst
      INT = 1'b1;
      for (int j = 0; j < 3; j++) begin
         txn($sformatf("ri%0d", j), {1'b1, 7'(7'h22 + j), 8'h00}, 2, 0, 8'hEE);
         INT = 1'b0;
      end
      vsnap = vld_cnt;
      reinit = 1'b1; tick(); reinit = 1'b0;
      re_edge = cyc;
      chk("ri_done_clr", init_done, 1'b0);
      chk("ri_wrt", spi.spi_wrt, 1'b0);
      spi.spi_done = 1'b1; tick(); spi.spi_done = 1'b0;
      wait_wrt("ri_init");
      chk("ri_cmd", spi.spi_cmd, 16'h0D02);
      chk("ri_gap", 80'(wrt_cyc - re_edge), 80'(PWR));
      chk("ri_no_vld", 80'(vld_cnt - vsnap), 80'd0);
      chk("ri_data", data, PAT);

      // rst while waiting on the first init write
      tick();
      rst = 1'b1; tick();
      chk("rst2_wrt", spi.spi_wrt, 1'b0);
      chk("rst2_cmd", spi.spi_cmd, 16'h0000);
      chk("rst2_done", init_done, 1'b0);
      chk("rst2_data", data, '0);
      chk("rst2_vld", vld, 1'b0);
      chk("rst2_tmo", tmo_err, 1'b0);
      chk("rst2_ovr", ovr_cnt, 8'd0);
      rst_edge = cyc;
      rst = 1'b0;
      run_init(rst_edge);
      burst(0);
      chk("rst2_ovr_end", ovr_cnt, 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: sim did not complete");
      $fatal(1, "timeout");
   end
endmodule
